elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
`default_nettype none
// elevator_scheduler: single-car scheduler that keeps travelling in one direction while targets remain ahead.
// Optional emergency stop (estop/halted ports, HALT state) is compiled in with ELEV_SCHED_ESTOP_EN.
module elevator_scheduler #(
   parameter int NUM_FLOORS  = 4,
   parameter int FLOOR_BITS  = 2,
   parameter int MOVE_CYCLES = 8,
   parameter int DOOR_CYCLES = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  req_valid,
   input  logic [FLOOR_BITS-1:0] req_floor,
`ifdef ELEV_SCHED_ESTOP_EN
   input  logic                  estop,
   output logic                  halted,
`endif
   output logic [NUM_FLOORS-1:0] pending,
   output logic [FLOOR_BITS-1:0] cur_floor,
   output logic                  dir_up,
   output logic                  moving,
   output logic                  door_open,
   output logic                  arrived
);

   localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

`ifdef ELEV_SCHED_ESTOP_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2, S_HALT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2} state_t;
`endif

   state_t                state_q, state_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [FLOOR_BITS-1:0] cur_floor_q, cur_floor_d;
   logic                  dir_up_q, dir_up_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  arrived_q, arrived_d;

   logic [FLOOR_BITS-1:0] nxt_floor;
   logic                  here_cur, above_cur, below_cur;
   logic                  here_nxt, above_nxt, below_nxt;
   logic                  req_ok;

   // Occupancy summaries relative to the current floor and the floor the car steps to next.
   always_comb begin
      nxt_floor = dir_up_q ? (cur_floor_q + FLOOR_BITS'(1)) : (cur_floor_q - FLOOR_BITS'(1));
      req_ok    = req_valid && (int'(req_floor) < NUM_FLOORS);
      here_cur  = 1'b0;
      above_cur = 1'b0;
      below_cur = 1'b0;
      here_nxt  = 1'b0;
      above_nxt = 1'b0;
      below_nxt = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_BITS'(i) == cur_floor_q) here_cur  = here_cur  | pending_q[i];
         if (FLOOR_BITS'(i) >  cur_floor_q) above_cur = above_cur | pending_q[i];
         if (FLOOR_BITS'(i) <  cur_floor_q) below_cur = below_cur | pending_q[i];
         if (FLOOR_BITS'(i) == nxt_floor)   here_nxt  = here_nxt  | pending_q[i];
         if (FLOOR_BITS'(i) >  nxt_floor)   above_nxt = above_nxt | pending_q[i];
         if (FLOOR_BITS'(i) <  nxt_floor)   below_nxt = below_nxt | pending_q[i];
      end
   end

   logic                  clr_en;
   logic [FLOOR_BITS-1:0] clr_floor;
   logic                  door_hit;

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      cur_floor_d = cur_floor_q;
      dir_up_d    = dir_up_q;
      cnt_d       = cnt_q;
      arrived_d   = 1'b0;
      clr_en      = 1'b0;
      clr_floor   = cur_floor_q;
      door_hit    = req_ok && (req_floor == cur_floor_q) && (state_q == S_DOOR);

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (here_cur) begin
               state_d = S_DOOR;
               clr_en  = 1'b1;
            end else if (dir_up_q ? above_cur : below_cur) begin
               state_d = S_MOVE;
            end else if (dir_up_q ? below_cur : above_cur) begin
               state_d  = S_MOVE;
               dir_up_d = ~dir_up_q;
            end
         end
         S_MOVE: begin
            if (cnt_q == MOVE_LAST) begin
               cnt_d       = '0;
               cur_floor_d = nxt_floor;
               arrived_d   = 1'b1;
               if (here_nxt) begin
                  state_d   = S_DOOR;
                  clr_en    = 1'b1;
                  clr_floor = nxt_floor;
               end else if (!(dir_up_q ? above_nxt : below_nxt)) begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DOOR: begin
            if (door_hit) begin
               cnt_d = '0;
            end else if (cnt_q == DOOR_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef ELEV_SCHED_ESTOP_EN
         S_HALT: begin
            if (!estop) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

`ifdef ELEV_SCHED_ESTOP_EN
      // Emergency stop freezes motion and the counter but keeps collecting requests.
      if (estop) begin
         state_d     = S_HALT;
         cnt_d       = cnt_q;
         cur_floor_d = cur_floor_q;
         dir_up_d    = dir_up_q;
         arrived_d   = 1'b0;
         clr_en      = 1'b0;
         door_hit    = 1'b0;
      end
`endif

      // Clear is applied after set so a request for a floor being served is absorbed.
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (req_ok && !door_hit && (FLOOR_BITS'(i) == req_floor)) pending_d[i] = 1'b1;
         if (clr_en && (FLOOR_BITS'(i) == clr_floor))              pending_d[i] = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         pending_q   <= '0;
         cur_floor_q <= '0;
         dir_up_q    <= 1'b1;
         cnt_q       <= '0;
         arrived_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         cur_floor_q <= cur_floor_d;
         dir_up_q    <= dir_up_d;
         cnt_q       <= cnt_d;
         arrived_q   <= arrived_d;
      end
   end

   assign pending   = pending_q;
   assign cur_floor = cur_floor_q;
   assign dir_up    = dir_up_q;
   assign moving    = (state_q == S_MOVE);
   assign door_open = (state_q == S_DOOR);
   assign arrived   = arrived_q;
`ifdef ELEV_SCHED_ESTOP_EN
   assign halted    = (state_q == S_HALT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// tb_elevator_scheduler: directed self-checking bench for elevator_scheduler (4 floors, 3-bit floor index).
module tb_elevator_scheduler;

   logic       ACLK = 1'b0;
   logic       ARESETN = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_floor = 3'd0;
   logic [3:0] pending;
   logic [2:0] cur_floor;
   logic       dir_up, moving, door_open, arrived;
`ifdef ELEV_SCHED_ESTOP_EN
   logic       estop = 1'b0;
   logic       halted;
`endif

   int checks = 0;
   int errors = 0;
   int n;

   always #5 ACLK = ~ACLK;

   elevator_scheduler #(
      .NUM_FLOORS (4),
      .FLOOR_BITS (3),
      .MOVE_CYCLES(8),
      .DOOR_CYCLES(4)
   ) dut (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .req_valid(req_valid),
      .req_floor(req_floor),
`ifdef ELEV_SCHED_ESTOP_EN
      .estop    (estop),
      .halted   (halted),
`endif
      .pending  (pending),
      .cur_floor(cur_floor),
      .dir_up   (dir_up),
      .moving   (moving),
      .door_open(door_open),
      .arrived  (arrived)
   );

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_req(input logic [2:0] f);
      req_valid = 1'b1;
      req_floor = f;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      // Reset values while held in reset
      tick();
      tick();
      chk("rst pending", pending, 0);
      chk("rst cur_floor", cur_floor, 0);
      chk("rst dir_up", dir_up, 1);
      chk("rst moving", moving, 0);
      chk("rst door_open", door_open, 0);
      chk("rst arrived", arrived, 0);
      ARESETN = 1'b1;
      tick();

      // Request at current floor: pending cycle 1, door cycles 2..5, idle cycle 6
      pulse_req(3'd0);
      chk("t1 c1 pending", pending, 4'b0001);
      chk("t1 c1 door", door_open, 0);
      tick();
      chk("t1 c2 door", door_open, 1);
      chk("t1 c2 pending", pending, 0);
      tick(); tick(); tick();
      chk("t1 c5 door", door_open, 1);
      tick();
      chk("t1 c6 door", door_open, 0);
      chk("t1 c6 moving", moving, 0);

      // Floor 0 -> 2: moving from cycle 2, arrivals at 10 and 18
      pulse_req(3'd2);
      chk("t2 c1 pending", pending, 4'b0100);
      chk("t2 c1 moving", moving, 0);
      tick();
      chk("t2 c2 moving", moving, 1);
      for (int i = 3; i <= 9; i++) tick();
      chk("t2 c9 cur", cur_floor, 0);
      chk("t2 c9 arrived", arrived, 0);
      tick();
      chk("t2 c10 cur", cur_floor, 1);
      chk("t2 c10 arrived", arrived, 1);
      chk("t2 c10 moving", moving, 1);
      tick();
      chk("t2 c11 arrived", arrived, 0);
      for (int i = 12; i <= 17; i++) tick();
      chk("t2 c17 cur", cur_floor, 1);
      tick();
      chk("t2 c18 cur", cur_floor, 2);
      chk("t2 c18 arrived", arrived, 1);
      chk("t2 c18 door", door_open, 1);
      chk("t2 c18 moving", moving, 0);
      chk("t2 c18 pending", pending, 0);
      tick(); tick(); tick();
      chk("t2 c21 door", door_open, 1);
      tick();
      chk("t2 c22 door", door_open, 0);

      // Repeated request at current floor keeps the door open
      pulse_req(3'd2);
      tick();
      chk("t3 c2 door", door_open, 1);
      req_valid = 1'b1;
      req_floor = 3'd2;
      for (int i = 2; i <= 6; i++) begin
         tick();
         chk("t3 hold pending", pending, 0);
      end
      req_valid = 1'b0;
      tick(); tick(); tick();
      chk("t3 c10 door", door_open, 1);
      tick();
      chk("t3 c11 door", door_open, 0);
      chk("t3 c11 pending", pending, 0);

      // Out-of-range floors are ignored
      pulse_req(3'd5);
      chk("t3 ign5 pending", pending, 0);
      pulse_req(3'd4);
      chk("t3 ign4 pending", pending, 0);
      tick(); tick();
      chk("t3 ign moving", moving, 0);
      chk("t3 ign door", door_open, 0);

      // Reverse to floor 1, then up to 3 with a floor-0 request mid-move
      pulse_req(3'd1);
      n = 0;
      while (!door_open && n < 40) begin tick(); n++; end
      chk("t4 door@1", door_open, 1);
      chk("t4 cur1", cur_floor, 1);
      chk("t4 dir down", dir_up, 0);
      n = 0;
      while (door_open && n < 10) begin tick(); n++; end
      pulse_req(3'd3);
      n = 0;
      while (!moving && n < 5) begin tick(); n++; end
      chk("t4 moving up", moving, 1);
      chk("t4 dir up", dir_up, 1);
      pulse_req(3'd0);
      n = 0;
      while (!door_open && n < 40) begin tick(); n++; end
      chk("t4 door@3", door_open, 1);
      chk("t4 cur3", cur_floor, 3);
      chk("t4 pend0 kept", pending, 4'b0001);
      n = 0;
      while (door_open && n < 10) begin tick(); n++; end
      n = 0;
      while (!moving && n < 5) begin tick(); n++; end
      chk("t4 moving down", moving, 1);
      chk("t4 dir flipped", dir_up, 0);
      n = 0;
      while (!door_open && n < 60) begin tick(); n++; end
      chk("t4 door@0", door_open, 1);
      chk("t4 cur0", cur_floor, 0);
      chk("t4 pend clear", pending, 0);

      // Reset mid-door with an outstanding request
      pulse_req(3'd2);
      chk("t5 pend pre", pending, 4'b0100);
      chk("t5 door pre", door_open, 1);
      ARESETN = 1'b0;
      #1;
      chk("t5 door rst", door_open, 0);
      chk("t5 pend rst", pending, 0);
      chk("t5 cur rst", cur_floor, 0);
      chk("t5 dir rst", dir_up, 1);
      chk("t5 moving rst", moving, 0);
      tick();
      ARESETN = 1'b1;
      tick();
      tick();
      chk("t5 idle after", door_open | moving, 0);

`ifdef ELEV_SCHED_ESTOP_EN
      // Emergency stop mid-move discards partial progress
      pulse_req(3'd2);
      tick();
      chk("t6 moving", moving, 1);
      tick(); tick(); tick();
      estop = 1'b1;
      tick();
      chk("t6 halted", halted, 1);
      chk("t6 halt moving", moving, 0);
      chk("t6 halt cur", cur_floor, 0);
      pulse_req(3'd3);
      for (int i = 0; i < 8; i++) tick();
      chk("t6 halt hold", halted, 1);
      chk("t6 halt pend", pending, 4'b1100);
      chk("t6 halt cur2", cur_floor, 0);
      estop = 1'b0;
      tick();
      chk("t6 release halted", halted, 0);
      chk("t6 release idle", moving, 0);
      tick();
      chk("t6 resume", moving, 1);
      for (int i = 0; i < 7; i++) tick();
      chk("t6 no early step", cur_floor, 0);
      tick();
      chk("t6 step cur", cur_floor, 1);
      chk("t6 step arrived", arrived, 1);
      n = 0;
      while (!door_open && n < 20) begin tick(); n++; end
      chk("t6 door@2", cur_floor, 2);
      ARESETN = 1'b0;
      #1;
      chk("t6 rst halted", halted, 0);
      chk("t6 rst door", door_open, 0);
      tick();
      ARESETN = 1'b1;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
